// File: rtl/ps2_key_event_fifo.sv
// ps2_key_event_fifo: folds PS/2 E0/F0/E1 prefixes into key events and queues them in a FWFT FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to drop auto-repeat make events of the currently held key.
module ps2_key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    scancode,
  input  logic          scancode_ready,
  output logic [7:0]    ev_code,
  output logic          ev_ext,
  output logic          ev_brk,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  input  logic          clear_overflow
);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
  state_t state, state_n;
  logic [2:0] pcnt, pcnt_n;
  logic emit, e_ext, e_brk, hk, rep, push, pop, full, wr;
  logic [9:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign hk = scancode inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFF};
  always_comb begin
    state_n = state;
    pcnt_n = pcnt;
    emit = 1'b0;
    e_ext = 1'b0;
    e_brk = 1'b0;
    if (scancode_ready) begin
      if (state == PAUSE) begin
        pcnt_n = pcnt - 3'd1;
        state_n = (pcnt == 3'd1) ? IDLE : PAUSE;
      end else if (scancode == 8'hE0) begin
        state_n = EXT;
      end else if (scancode == 8'hF0) begin
        state_n = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
      end else if (scancode == 8'hE1 && state == IDLE) begin
        emit = 1'b1;
        pcnt_n = 3'd7;
        state_n = PAUSE;
      end else if (hk) begin
        state_n = IDLE;
      end else begin
        emit = 1'b1;
        e_ext = (state == EXT || state == EXT_BRK);
        e_brk = (state == BRK || state == EXT_BRK);
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pcnt <= 3'd0;
    end else begin
      state <= state_n;
      pcnt <= pcnt_n;
    end
  end
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic hv, hx;
  logic [7:0] hc;
  logic hit;
  assign hit = hv && hx == e_ext && hc == scancode;
  assign rep = emit & ~e_brk & hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      hv <= 1'b0;
      hx <= 1'b0;
      hc <= 8'h00;
    end else if (emit && !e_brk && !hit) begin
      hv <= 1'b1;
      hx <= e_ext;
      hc <= scancode;
    end else if (emit && e_brk && hit) begin
      hv <= 1'b0;
    end
  end
`else
  assign rep = 1'b0;
`endif
  assign push = emit & ~rep;
  assign ev_valid = fifo_count != '0;
  assign full = fifo_count == (AW+1)'(DEPTH);
  assign pop = ev_valid & ev_ready;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign wr = push & (~full | pop);
  assign {ev_ext, ev_brk, ev_code} = mem[rp];
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {e_ext, e_brk, scancode};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_count <= fifo_count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      overflow <= (push & full & ~pop) | (overflow & ~clear_overflow);
    end
  end
endmodule
